// File: rtl/gemm_drain_pkg.sv
// gemm_drain_pkg: shared state codes, element type and slice helpers for the C-drain reader.
package gemm_drain_pkg;

    localparam int CElemWidth = 32;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_EMIT = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    typedef logic signed [CElemWidth-1:0] c_elem_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lsb(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/gemm_c_addr_gen.sv
// gemm_c_addr_gen: tm/r/tn/j walk counters, tile address and end-of-row/end-of-matrix detection.
module gemm_c_addr_gen
    import gemm_drain_pkg::*;
#(
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int AddrWidth     = 6,
    parameter int SizeAddrWidth = 8,
    parameter int JW            = idx_w(N),
    parameter int RW            = idx_w(M)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load,
    input  logic                     adv,
    input  logic                     ahead,
    input  logic [SizeAddrWidth-1:0] tiles_m,
    input  logic [SizeAddrWidth-1:0] tiles_n,
    output logic [JW-1:0]            j,
    output logic [RW-1:0]            sel_r,
    output logic [AddrWidth-1:0]     addr,
    output logic                     row_end,
    output logic                     final_beat
);

    logic [SizeAddrWidth-1:0] tm, tn, tm_sz, tn_sz, nx_tm, nx_tn;
    logic [RW-1:0]            r, nx_r;
    logic                     last_tn, last_r;

    // ahead selects the tile row that follows the current one (prefetch target)
    always_comb begin
        last_tn    = tn == tn_sz - 1'b1;
        last_r     = r == RW'(M - 1);
        row_end    = j == JW'(N - 1);
        final_beat = row_end && last_tn && last_r && tm == tm_sz - 1'b1;
        nx_tn      = last_tn ? '0 : tn + 1'b1;
        nx_r       = last_tn ? (last_r ? '0 : r + 1'b1) : r;
        nx_tm      = (last_tn && last_r) ? tm + 1'b1 : tm;
        sel_r      = ahead ? nx_r : r;
        addr       = AddrWidth'(ahead ? nx_tm * tn_sz + nx_tn : tm * tn_sz + tn);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tm    <= '0;
            tn    <= '0;
            tm_sz <= '0;
            tn_sz <= '0;
            r     <= '0;
            j     <= '0;
        end else if (load) begin
            tm_sz <= tiles_m;
            tn_sz <= tiles_n;
            tm    <= '0;
            tn    <= '0;
            r     <= '0;
            j     <= '0;
        end else if (adv) begin
            j <= row_end ? '0 : j + 1'b1;
            if (row_end) begin
                tm <= nx_tm;
                tn <= nx_tn;
                r  <= nx_r;
            end
        end
    end

endmodule

// File: rtl/gemm_c_drain.sv
// gemm_c_drain: streams tiled SRAM C back out row-major over valid/ready.
// C_DRAIN_PREFETCH_EN adds a second row buffer fetched during EMIT for 1 element/cycle.
module gemm_c_drain
    import gemm_drain_pkg::*;
#(
    parameter int OutDataWidth  = CElemWidth,
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int AddrWidth     = 6,
    parameter int SizeAddrWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [SizeAddrWidth-1:0]     M_size_i,
    input  logic [SizeAddrWidth-1:0]     N_size_i,
    output logic [AddrWidth-1:0]         sram_c_addr_o,
    input  logic [OutDataWidth*M*N-1:0]  sram_c_rdata_i,
    output logic [OutDataWidth-1:0]      out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int JW = idx_w(N);
    localparam int RW = idx_w(M);

    state_t                          state, state_nx;
    logic signed [OutDataWidth-1:0]  row_buf [N];
    logic [SizeAddrWidth-1:0]        tiles_m, tiles_n;
    logic [JW-1:0]                   j;
    logic [RW-1:0]                   sel_r;
    logic [AddrWidth-1:0]            addr;
    logic                            row_end, final_beat, load, row_done, ahead, swap;

    always_comb begin
        tiles_m       = M_size_i / SizeAddrWidth'(M);
        tiles_n       = N_size_i / SizeAddrWidth'(N);
        load          = state == ST_IDLE && start_i && tiles_m != '0 && tiles_n != '0;
        out_valid_o   = state == ST_EMIT;
        row_done      = out_valid_o && out_ready_i && row_end;
        out_data_o    = out_valid_o ? row_buf[j] : '0;
        out_last_o    = out_valid_o && final_beat;
        busy_o        = state == ST_REQ || state == ST_WAIT || state == ST_EMIT;
        done_o        = state == ST_DONE;
        sram_c_addr_o = busy_o ? addr : '0;
        state_nx      = state == ST_IDLE ? (start_i ? (load ? ST_REQ : ST_DONE) : ST_IDLE)
                      : state == ST_REQ  ? ST_WAIT
                      : state == ST_WAIT ? ST_EMIT
                      : state == ST_EMIT ? (row_done ? (final_beat ? ST_DONE : (swap ? ST_EMIT : ST_REQ)) : ST_EMIT)
                      : ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nx;
    end

`ifdef C_DRAIN_PREFETCH_EN
    logic signed [OutDataWidth-1:0] pf_buf [N];
    logic                           pf_ok, pf_full;
    assign ahead = state == ST_EMIT;
    assign swap  = pf_full;
    // pf_ok: the prefetch address has been stable for a cycle, so rdata now belongs to it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pf_ok   <= 1'b0;
            pf_full <= 1'b0;
        end else begin
            pf_ok   <= ahead && !row_done;
            pf_full <= row_done ? 1'b0 : ((ahead && pf_ok) ? 1'b1 : pf_full);
        end
    end
    always_ff @(posedge clk_i) begin
        if (ahead && pf_ok)
            for (int c = 0; c < N; c++)
                pf_buf[c] <= sram_c_rdata_i[slice_lsb(int'(sel_r), c, N, OutDataWidth) +: OutDataWidth];
    end
`else
    assign ahead = 1'b0;
    assign swap  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (state == ST_WAIT) begin
            for (int c = 0; c < N; c++)
                row_buf[c] <= sram_c_rdata_i[slice_lsb(int'(sel_r), c, N, OutDataWidth) +: OutDataWidth];
        end
`ifdef C_DRAIN_PREFETCH_EN
        else if (row_done && pf_full) begin
            for (int c = 0; c < N; c++)
                row_buf[c] <= pf_buf[c];
        end
`endif
    end

    gemm_c_addr_gen #(
        .M             (M),
        .N             (N),
        .AddrWidth     (AddrWidth),
        .SizeAddrWidth (SizeAddrWidth)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load       (load),
        .adv        (out_valid_o && out_ready_i),
        .ahead      (ahead),
        .tiles_m    (tiles_m),
        .tiles_n    (tiles_n),
        .j          (j),
        .sel_r      (sel_r),
        .addr       (addr),
        .row_end    (row_end),
        .final_beat (final_beat)
    );

endmodule

// File: tb/tb_gemm_c_drain.sv
// tb_gemm_c_drain: directed checks of the C-drain reader against a tiled SRAM model.
module tb_gemm_c_drain;
    import gemm_drain_pkg::*;

    localparam int W  = 32;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int SW = 8;

    logic              clk = 0, rst_n = 0, start = 0, ready = 1;
    logic [SW-1:0]     m_size = '0, n_size = '0;
    logic [AW-1:0]     addr;
    logic [W*M*N-1:0]  rdata = '0;
    logic [W*M*N-1:0]  mem [64];
    logic [W-1:0]      data;
    logic              valid, last, busy, done;

    int      tests = 0, fails = 0, cyc = 0, nb = 0, dones = 0, n_last = 0;
    int      first_cyc, done_cyc, last_cyc, start_cyc;
    c_elem_t beats [256];
    bit      lasts [256];
    bit      hold_chk = 0;
    logic [W-1:0] hold_d;

    gemm_c_drain #(.OutDataWidth(W), .M(M), .N(N), .AddrWidth(AW), .SizeAddrWidth(SW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .M_size_i       (m_size),
        .N_size_i       (n_size),
        .sram_c_addr_o  (addr),
        .sram_c_rdata_i (rdata),
        .out_data_o     (data),
        .out_valid_o    (valid),
        .out_ready_i    (ready),
        .out_last_o     (last),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdata <= mem[addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hold_chk) begin
            check("hold_valid", {31'd0, valid}, 1);
            check("hold_data", data, hold_d);
        end
        hold_chk = rst_n && valid && !ready;
        hold_d   = data;
        if (rst_n && valid && first_cyc < 0) first_cyc = cyc;
        if (rst_n && valid && ready && nb < 256) begin
            beats[nb] = data;
            lasts[nb] = last;
            if (last) last_cyc = cyc;
            n_last += int'(last);
            nb++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic load_mat(input int mi, input int ni);
        for (int a = 0; a < 64; a++) mem[a] = '0;
        for (int gr = 0; gr < mi; gr++)
            for (int gc = 0; gc < ni; gc++)
                mem[(gr / M) * (ni / N) + gc / N][((gr % M) * N + gc % N) * W +: W] = W'(gr * ni + gc);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, valid}, 0);
        check({tag, "_last"}, {31'd0, last}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_addr"}, {26'd0, addr}, 0);
        check({tag, "_data"}, data, 0);
    endtask

    // mode: 0 plain, 1 stall 5 cycles at beat 10, 2 reset at beat 20, 3 second start at beat 5
    task automatic run(input int mi, input int ni, input int mode);
        int stall_left = 0;
        bit fired = 0;
        nb = 0; dones = 0; n_last = 0;
        first_cyc = -1; done_cyc = -1; last_cyc = -1;
        m_size = SW'(mi); n_size = SW'(ni); start = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 0; m_size = 8'd4; n_size = 8'd4;
        if (mi >= M && ni >= N) check("busy_after_start", {31'd0, busy}, 1);
        for (int k = 0; k < 3000 && dones == 0; k++) begin
            if (mode == 1 && nb == 10 && !fired) begin fired = 1; stall_left = 5; end
            ready = stall_left == 0;
            if (stall_left > 0) stall_left--;
            if (mode == 3 && nb == 5 && !fired) begin fired = 1; start = 1; end
            else start = 0;
            if (mode == 2 && nb == 20) begin
                rst_n = 0;
                @(posedge clk); #1;
                check_idle("mid_reset");
                check("no_done_on_reset", dones, 0);
                rst_n = 1;
                return;
            end
            @(posedge clk); #1;
        end
        ready = 1; start = 0;
        if (dones == 0) check("timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", dones, 1);
    endtask

    task automatic verify(input int n);
        check("beat_count", nb, n);
        for (int i = 0; i < n; i++) check($sformatf("beat%0d", i), beats[i], i);
        check("last_count", n_last, 1);
        check("last_pos", {31'd0, lasts[n - 1]}, 1);
        check("done_after_last", done_cyc - last_cyc, 1);
    endtask

    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1;

        load_mat(4, 4);
        run(4, 4, 0);
        verify(16);
        check("first_valid_lat", first_cyc - start_cyc, 3);

        load_mat(8, 8);
        run(8, 8, 0);
        verify(64);
        check("first_valid_lat8", first_cyc - start_cyc, 3);
`ifdef C_DRAIN_PREFETCH_EN
        check("prefetch_runtime", {31'd0, (done_cyc - start_cyc) <= 68}, 1);
`endif

        run(8, 8, 1);
        verify(64);

        run(0, 8, 0);
        check("degen_m_beats", nb, 0);
        check("degen_m_done_lat", done_cyc - start_cyc, 1);
        run(8, 3, 0);
        check("degen_n_beats", nb, 0);
        check("degen_n_done_lat", done_cyc - start_cyc, 1);

        run(8, 8, 2);
        run(8, 8, 0);
        verify(64);

        run(8, 8, 3);
        verify(64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
